// File: rtl/clock_speed_ctrl_if.sv
// -----------------------------------------------------------------------------
// clock_speed_ctrl_if
//   Groups the configuration, address-decode and clock-switch handshake
//   signals of clock_speed_ctrl.
//
//   Signals:
//     enable_hs_ip   - turbo enable; 0 forces LS operation
//     valid_ip       - address valid this cycle, qualifies need_ls_ip
//     need_ls_ip     - access this cycle targets LS-only space
//     selected_hs_ip - switch feedback, HS clock path enabled
//     selected_ls_ip - switch feedback, LS clock path enabled
//     select_hs_op   - registered select request to the clock switch
//     state_op       - FSM state (LS_RUN=00 HS_REQ=01 HS_RUN=10 LS_REQ=11)
//     switching_op   - 1 while a switch request is outstanding
//     timeout_err_op - sticky switch-timeout flag
//
//   Modports:
//     master - the side that drives decode/feedback (system or bench)
//     slave  - the sequencer itself
// -----------------------------------------------------------------------------
interface clock_speed_ctrl_if;
   logic       enable_hs_ip;
   logic       valid_ip;
   logic       need_ls_ip;
   logic       selected_hs_ip;
   logic       selected_ls_ip;
   logic       select_hs_op;
   logic [1:0] state_op;
   logic       switching_op;
   logic       timeout_err_op;

   modport master (
      output enable_hs_ip, valid_ip, need_ls_ip, selected_hs_ip, selected_ls_ip,
      input  select_hs_op, state_op, switching_op, timeout_err_op
   );

   modport slave (
      input  enable_hs_ip, valid_ip, need_ls_ip, selected_hs_ip, selected_ls_ip,
      output select_hs_op, state_op, switching_op, timeout_err_op
   );
endinterface

// File: rtl/clock_speed_ctrl.sv
// -----------------------------------------------------------------------------
// clock_speed_ctrl
//   Sequencer driving the select input of the HS/LS glitch-free clock switch.
//   Each CPU cycle it decides whether the next cycle may run from the
//   high-speed clock or must drop to the low-speed (host bus) clock, waits for
//   the switch to acknowledge, enforces a minimum LS dwell time and flags
//   switches that never complete.
//
//   Ports:
//     ck_ip    - switched CPU clock; all state changes on its falling edge
//     reset_ip - asynchronous active-high reset
//     bus      - clock_speed_ctrl_if.slave (decode, feedback and status)
//
//   Parameters:
//     DWELL_LS / DWELL_W - minimum LS_RUN cycles before an HS request
//     TIMEOUT  / TO_W    - cycles allowed in a request state before timeout
// -----------------------------------------------------------------------------
module clock_speed_ctrl #(
   parameter int DWELL_LS = 4,
   parameter int DWELL_W  = 4,
   parameter int TIMEOUT  = 15,
   parameter int TO_W     = 4
) (
   input  logic               ck_ip,
   input  logic               reset_ip,
   clock_speed_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      LS_RUN = 2'b00,
      HS_REQ = 2'b01,
      HS_RUN = 2'b10,
      LS_REQ = 2'b11
   } state_t;

   localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(DWELL_LS);
   localparam logic [TO_W-1:0]    TO_MAX    = TO_W'(TIMEOUT);

   state_t             state_reg, state_next;
   logic [DWELL_W-1:0] dwell_reg, dwell_next;
   logic [TO_W-1:0]    to_reg, to_next;
   logic [TO_W-1:0]    to_inc;
   logic               to_hit;
   logic               err_reg, err_next;
   logic               select_hs_reg, select_hs_next;
   logic               switching_reg, switching_next;

   logic ls_need, hs_ok, hs_fb, ls_fb;

   assign ls_need = bus.valid_ip & bus.need_ls_ip;
   assign hs_ok   = bus.enable_hs_ip & ~ls_need;
   // Both feedback bits high is illegal and therefore never counts as arrival.
   assign hs_fb   = bus.selected_hs_ip & ~bus.selected_ls_ip;
   assign ls_fb   = bus.selected_ls_ip & ~bus.selected_hs_ip;

   // Saturating increment; "reaching" TIMEOUT is judged on the value this
   // edge would store, so the flag rises on the TIMEOUT-th cycle in a request.
   assign to_inc = (to_reg == TO_MAX) ? to_reg : to_reg + 1'b1;
   assign to_hit = (to_inc == TO_MAX);

   always_comb begin
      state_next = state_reg;
      dwell_next = dwell_reg;
      to_next    = to_reg;
      err_next   = err_reg;

      case (state_reg)
         LS_RUN: begin
            if (dwell_reg != DWELL_MAX) begin
               dwell_next = dwell_reg + 1'b1;
            end else if (hs_ok) begin
               state_next = HS_REQ;
               to_next    = '0;
            end
         end
         HS_REQ: begin
            to_next = to_inc;
            // Abort beats HS arrival in the same cycle.
            if (!hs_ok) begin
               state_next = LS_REQ;
               to_next    = '0;
            end else if (hs_fb) begin
               state_next = HS_RUN;
            end else if (to_hit) begin
               err_next   = 1'b1;
               state_next = LS_REQ;
               to_next    = '0;
            end
         end
         HS_RUN: begin
            if (!hs_ok) begin
               state_next = LS_REQ;
               to_next    = '0;
            end
         end
         LS_REQ: begin
            to_next = to_inc;
            if (ls_fb) begin
               state_next = LS_RUN;
               dwell_next = '0;
               to_next    = '0;
            end else if (to_hit) begin
               // No fallback exists below LS: flag and keep waiting.
               err_next = 1'b1;
            end
         end
         default: begin
            state_next = LS_RUN;
            dwell_next = '0;
            to_next    = '0;
         end
      endcase

      // Outputs are registered from the next state so the switch select has
      // no combinational path from any input.
      select_hs_next = (state_next == HS_REQ) || (state_next == HS_RUN);
      switching_next = (state_next == HS_REQ) || (state_next == LS_REQ);
   end

   // Falling edge: the select changes only at the start of the low phase.
   always_ff @(negedge ck_ip or posedge reset_ip) begin
      if (reset_ip) begin
         state_reg     <= LS_RUN;
         dwell_reg     <= '0;
         to_reg        <= '0;
         err_reg       <= 1'b0;
         select_hs_reg <= 1'b0;
         switching_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         dwell_reg     <= dwell_next;
         to_reg        <= to_next;
         err_reg       <= err_next;
         select_hs_reg <= select_hs_next;
         switching_reg <= switching_next;
      end
   end

   assign bus.select_hs_op   = select_hs_reg;
   assign bus.state_op       = state_reg;
   assign bus.switching_op   = switching_reg;
   assign bus.timeout_err_op = err_reg;

endmodule

// File: tb/tb_clock_speed_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clock_speed_ctrl
//   Directed bench for clock_speed_ctrl. The DUT updates on the falling edge of
//   ck; inputs are changed and outputs sampled 1 time unit after that edge.
// -----------------------------------------------------------------------------
module tb_clock_speed_ctrl;

   logic ck  = 1'b1;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;

   clock_speed_ctrl_if bus ();

   clock_speed_ctrl #(
      .DWELL_LS (4),
      .DWELL_W  (4),
      .TIMEOUT  (15),
      .TO_W     (4)
   ) dut (
      .ck_ip    (ck),
      .reset_ip (rst),
      .bus      (bus)
   );

   always #5 ck = ~ck;

   task automatic tick(input int n);
      repeat (n) @(negedge ck);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
         $error("%s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [1:0] st, input logic sel,
                            input logic sw, input logic err);
      check({tag, "_state"}, 8'(bus.state_op), 8'(st));
      check({tag, "_sel"},   8'(bus.select_hs_op), 8'(sel));
      check({tag, "_sw"},    8'(bus.switching_op), 8'(sw));
      check({tag, "_err"},   8'(bus.timeout_err_op), 8'(err));
   endtask

   task automatic fb(input logic hs, input logic ls);
      bus.selected_hs_ip = hs;
      bus.selected_ls_ip = ls;
   endtask

   initial begin
      bus.enable_hs_ip = 1'b1;
      bus.valid_ip     = 1'b0;
      bus.need_ls_ip   = 1'b0;
      fb(1'b0, 1'b1);

      // Reset values, held across clock edges.
      #3;
      check_all("rst", 2'b00, 1'b0, 1'b0, 1'b0);
      tick(2);
      check_all("rst_held", 2'b00, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      $display("[TB] step: reset released");

      // Four edges in LS_RUN, HS request on the fifth.
      for (int k = 1; k <= 4; k++) begin
         tick(1);
         check("dwell_state", 8'(bus.state_op), 8'h0);
         check("dwell_sel", 8'(bus.select_hs_op), 8'h0);
      end
      tick(1);
      check_all("hs_req", 2'b01, 1'b1, 1'b1, 1'b0);
      $display("[TB] step: HS request issued");

      fb(1'b1, 1'b0);
      tick(1);
      check_all("hs_run", 2'b10, 1'b1, 1'b0, 1'b0);
      $display("[TB] step: HS running");

      // One-cycle LS access drops the select on that edge.
      bus.valid_ip   = 1'b1;
      bus.need_ls_ip = 1'b1;
      tick(1);
      check_all("ls_req", 2'b11, 1'b0, 1'b1, 1'b0);
      bus.valid_ip   = 1'b0;
      bus.need_ls_ip = 1'b0;
      fb(1'b0, 1'b1);
      tick(1);
      check_all("ls_run", 2'b00, 1'b0, 1'b0, 1'b0);
      $display("[TB] step: back in LS_RUN");

      // Dwell re-applies after returning from HS.
      for (int k = 1; k <= 4; k++) begin
         tick(1);
         check("redwell_state", 8'(bus.state_op), 8'h0);
      end
      tick(1);
      check("rereq_state", 8'(bus.state_op), 8'h1);

      // Abort and HS arrival on the same edge: abort wins.
      fb(1'b1, 1'b0);
      bus.valid_ip   = 1'b1;
      bus.need_ls_ip = 1'b1;
      tick(1);
      check_all("abort", 2'b11, 1'b0, 1'b1, 1'b0);
      bus.valid_ip   = 1'b0;
      bus.need_ls_ip = 1'b0;
      fb(1'b0, 1'b1);
      tick(1);
      check("abort_done", 8'(bus.state_op), 8'h0);
      $display("[TB] step: abort resolved to LS");

      // HS_REQ timeout with feedback stuck at LS.
      tick(5);
      check("to_req", 8'(bus.state_op), 8'h1);
      tick(14);
      check_all("to_pre", 2'b01, 1'b1, 1'b1, 1'b0);
      tick(1);
      check_all("to_hit", 2'b11, 1'b0, 1'b1, 1'b1);
      tick(1);
      check_all("to_back", 2'b00, 1'b0, 1'b0, 1'b1);
      $display("[TB] step: HS request timed out");

      // Turbo disabled: LS forever.
      bus.enable_hs_ip = 1'b0;
      for (int k = 0; k < 100; k++) begin
         tick(1);
         check("nohs_state", 8'(bus.state_op), 8'h0);
         check("nohs_sel", 8'(bus.select_hs_op), 8'h0);
      end
      check("nohs_err", 8'(bus.timeout_err_op), 8'h1);
      $display("[TB] step: turbo disabled for 100 cycles");

      // Dwell is already saturated, so the request follows at once.
      bus.enable_hs_ip = 1'b1;
      tick(1);
      check("reen_req", 8'(bus.state_op), 8'h1);
      fb(1'b1, 1'b0);
      tick(1);
      check_all("reen_run", 2'b10, 1'b1, 1'b0, 1'b1);

      // Asynchronous reset mid-cycle during HS_RUN.
      #2 rst = 1'b1;
      #1;
      check_all("async_rst", 2'b00, 1'b0, 1'b0, 1'b0);
      $display("[TB] step: asynchronous reset in HS_RUN");
      tick(1);
      fb(1'b0, 1'b1);
      rst = 1'b0;

      // LS_REQ timeout: stays waiting; both-high feedback is not arrival.
      tick(5);
      check("ls_to_req", 8'(bus.state_op), 8'h1);
      fb(1'b1, 1'b0);
      tick(1);
      check("ls_to_run", 8'(bus.state_op), 8'h2);
      bus.enable_hs_ip = 1'b0;
      tick(1);
      check("ls_to_enter", 8'(bus.state_op), 8'h3);
      fb(1'b1, 1'b1);
      tick(14);
      check_all("ls_to_pre", 2'b11, 1'b0, 1'b1, 1'b0);
      tick(1);
      check_all("ls_to_hit", 2'b11, 1'b0, 1'b1, 1'b1);
      tick(3);
      check_all("ls_to_wait", 2'b11, 1'b0, 1'b1, 1'b1);
      fb(1'b0, 1'b1);
      tick(1);
      check_all("ls_to_done", 2'b00, 1'b0, 1'b0, 1'b1);
      $display("[TB] step: LS request timeout and recovery");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
